// File: rtl/cp0_intr_ctrl.sv
// CP0 exception/interrupt block: Status (12), Cause (13) and EPC (14), hardware interrupt
// synchronisers, exception entry/ERET sequencing and the masked interrupt request.
module cp0_intr_ctrl #(
  parameter int unsigned NUM_HW_INT  = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_BEV   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic                  eret,
  output logic                  int_req,
  output logic [31:0]           epc_out,
  output logic                  exl,
  output logic                  erl,
  output logic                  bev
);

  localparam logic [4:0] AddrStatus = 5'd12;
  localparam logic [4:0] AddrCause  = 5'd13;
  localparam logic [4:0] AddrEpc    = 5'd14;

  // Status fields
  logic       bev_q, bev_d;
  logic [7:0] im_q, im_d;
  logic       erl_q, erl_d;
  logic       exl_q, exl_d;
  logic       ie_q, ie_d;
  // Cause fields
  logic       bd_q, bd_d;
  logic [1:0] ip_sw_q, ip_sw_d;
  logic [4:0] code_q, code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] sync_q;

  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic [31:0] status_val;
  logic [31:0] cause_val;

  // IP[7:2] follows the last synchroniser stage level; unimplemented lines read 0.
  always_comb begin
    hw_ip = '0;
    hw_ip[NUM_HW_INT-1:0] = sync_q[SYNC_STAGES-1];
  end

  assign ip         = {hw_ip, ip_sw_q};
  assign status_val = {9'b0, bev_q, 6'b0, im_q, 5'b0, erl_q, exl_q, ie_q};
  assign cause_val  = {bd_q, 15'b0, ip, 1'b0, code_q, 2'b0};

  always_comb begin
    bev_d   = bev_q;
    im_d    = im_q;
    erl_d   = erl_q;
    exl_d   = exl_q;
    ie_d    = ie_q;
    bd_d    = bd_q;
    ip_sw_d = ip_sw_q;
    code_d  = code_q;
    epc_d   = epc_q;

    // Lowest priority first so later assignments override per field.
    if (we) begin
      unique case (waddr)
        AddrStatus: begin
          bev_d = wdata[22];
          im_d  = wdata[15:8];
          erl_d = wdata[2];
          exl_d = wdata[1];
          ie_d  = wdata[0];
        end
        AddrCause: ip_sw_d = wdata[9:8];
        AddrEpc:   epc_d   = wdata;
        default: ;
      endcase
    end

    if (eret && !exc_valid) begin
      if (erl_q) erl_d = 1'b0;
      else       exl_d = 1'b0;
    end

    if (exc_valid) begin
      exl_d  = 1'b1;
      code_d = exc_code;
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        bd_d  = exc_bd;
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bev_q   <= RESET_BEV;
      im_q    <= 8'hff;
      erl_q   <= 1'b0;
      exl_q   <= 1'b0;
      ie_q    <= 1'b1;
      bd_q    <= 1'b0;
      ip_sw_q <= 2'b0;
      code_q  <= 5'b0;
      epc_q   <= 32'b0;
      sync_q  <= '0;
    end else begin
      bev_q   <= bev_d;
      im_q    <= im_d;
      erl_q   <= erl_d;
      exl_q   <= exl_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      ip_sw_q <= ip_sw_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      sync_q[0] <= hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  always_comb begin
    rdata = 32'b0;
    unique case (raddr)
      AddrStatus: rdata = status_val;
      AddrCause:  rdata = cause_val;
      AddrEpc:    rdata = epc_q;
      default: ;
    endcase
  end

  assign int_req = ie_q & ~exl_q & ~erl_q & (|(ip & im_q));
  assign epc_out = epc_q;
  assign exl     = exl_q;
  assign erl     = erl_q;
  assign bev     = bev_q;

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed bench for cp0_intr_ctrl: inputs driven on falling edges, outputs checked
// on the following falling edge against hand-computed values.
module tb_cp0_intr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic        int_req;
  logic [31:0] epc_out;
  logic        exl;
  logic        erl;
  logic        bev;

  int n_cmp = 0;
  int n_err = 0;

  cp0_intr_ctrl #(
    .NUM_HW_INT (6),
    .SYNC_STAGES(2),
    .RESET_BEV  (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .hw_int   (hw_int),
    .exc_valid(exc_valid),
    .exc_code (exc_code),
    .exc_pc   (exc_pc),
    .exc_bd   (exc_bd),
    .eret     (eret),
    .int_req  (int_req),
    .epc_out  (epc_out),
    .exl      (exl),
    .erl      (erl),
    .bev      (bev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    raddr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
    tick();
    exc_valid = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; hw_int = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; eret = 1'b0;

    // Asynchronous reset asserted mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    rd(5'd12, "rst_status", 32'h0040FF01);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    check("rst_mode", {29'b0, bev, erl, exl}, 32'h4);
    check("rst_epc_out", epc_out, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // hw_int[3]: two-edge latency on both rising and falling edges.
    hw_int[3] = 1'b1;
    tick();
    check("hw3_rise_1edge", {31'b0, int_req}, 32'h0);
    tick();
    check("hw3_rise_2edge", {31'b0, int_req}, 32'h1);
    rd(5'd13, "hw3_cause", 32'h00002000);
    hw_int[3] = 1'b0;
    tick();
    check("hw3_fall_1edge", {31'b0, int_req}, 32'h1);
    tick();
    check("hw3_fall_2edge", {31'b0, int_req}, 32'h0);

    // hw_int[0] held high through exception entry.
    hw_int[0] = 1'b1;
    tick();
    tick();
    check("hw0_req", {31'b0, int_req}, 32'h1);
    exc(5'd4, 32'h00400010, 1'b1);
    check("exc1_epc", epc_out, 32'h0040000C);
    check("exc1_exl", {31'b0, exl}, 32'h1);
    check("exc1_int_req", {31'b0, int_req}, 32'h0);
    rd(5'd13, "exc1_cause", 32'h80000410);
    exc(5'd5, 32'h12345678, 1'b0);
    check("exc2_epc", epc_out, 32'h0040000C);
    rd(5'd13, "exc2_cause", 32'h80000414);

    // ERET with ERL and EXL both set.
    mtc0(5'd12, 32'h0040FF07);
    check("erl_set", {30'b0, erl, exl}, 32'h3);
    do_eret();
    check("eret1_mode", {30'b0, erl, exl}, 32'h1);
    check("eret1_int_req", {31'b0, int_req}, 32'h0);
    do_eret();
    check("eret2_mode", {30'b0, erl, exl}, 32'h0);
    check("eret2_int_req", {31'b0, int_req}, 32'h1);
    rd(5'd12, "eret2_status", 32'h0040FF01);

    // Software interrupt bits through Cause.
    hw_int[0] = 1'b0;
    tick();
    tick();
    check("hw0_gone", {31'b0, int_req}, 32'h0);
    mtc0(5'd13, 32'hFFFFFFFF);
    rd(5'd13, "sw_cause", 32'h80000314);
    check("sw_int_req", {31'b0, int_req}, 32'h1);
    we = 1'b1; waddr = 5'd12; wdata = 32'h0040FC01;
    rd(5'd12, "status_old_on_write", 32'h0040FF01);
    tick();
    we = 1'b0;
    check("im_cleared_req", {31'b0, int_req}, 32'h0);
    rd(5'd7, "unmapped_read", 32'h0);

    // Collision: exception + eret + Status write in the same cycle.
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h00000100; exc_bd = 1'b0; eret = 1'b1;
    we = 1'b1; waddr = 5'd12; wdata = 32'h0040FF00;
    rd(5'd12, "coll_old_status", 32'h0040FC01);
    tick();
    exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
    rd(5'd12, "coll_status", 32'h0040FF02);
    rd(5'd13, "coll_cause", 32'h00000320);
    check("coll_epc", epc_out, 32'h00000100);
    check("coll_int_req", {31'b0, int_req}, 32'h0);

    // Full-width EPC write, then reset mid-cycle with a line held high.
    mtc0(5'd14, 32'hDEADBEEF);
    rd(5'd14, "epc_write", 32'hDEADBEEF);
    hw_int[1] = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    rd(5'd12, "rst2_status", 32'h0040FF01);
    check("rst2_epc", epc_out, 32'h0);
    rd(5'd13, "rst2_cause", 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("resync_1edge", {31'b0, int_req}, 32'h0);
    tick();
    check("resync_2edge", {31'b0, int_req}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_intr_ctrl.md
# cp0_intr_ctrl

Parametrised CP0 exception/interrupt block for the pipelined MIPS core. It replaces the standalone Status register with Status (12), Cause (13) and EPC (14). It adds synchronised hardware interrupt lines, software interrupt bits, exception entry and ERET handling, and a masked interrupt request to the pipeline control. It sits beside the MEM/WB stage: the core issues mtc0/mfc0 accesses, exception commits and eret to it, and it returns `int_req`, `epc_out` and mode bits.

## Interface
- `NUM_HW_INT`, 6: hardware interrupt lines, 1..6, mapped to Cause.IP[2+i].
- `SYNC_STAGES`, 2: synchroniser flops per hardware line, 2..4.
- `RESET_BEV`, 1: Status.BEV value after reset.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `we` in 1: mtc0 write strobe.
- `waddr` in 5: mtc0 register number.
- `wdata` in 32: mtc0 data.
- `raddr` in 5: mfc0 register number.
- `rdata` out 32: mfc0 data, combinational.
- `hw_int` in NUM_HW_INT: asynchronous level-sensitive interrupt lines.
- `exc_valid` in 1: exception commit (including interrupt acceptance, code 0), one-cycle pulse.
- `exc_code` in 5: ExcCode of committing exception.
- `exc_pc` in 32: PC of faulting instruction.
- `exc_bd` in 1: faulting instruction is in a branch delay slot.
- `eret` in 1: eret commit, one-cycle pulse.
- `int_req` out 1: enabled, unmasked interrupt pending.
- `epc_out` out 32: current EPC.
- `exl` out 1, `erl` out 1, `bev` out 1: Status mode bits.

## Operation
- Status layout: BEV[22], IM[15:8], ERL[2], EXL[1], IE[0]. All other bits read 0.
- Cause layout: BD[31], IP[15:8], ExcCode[6:2]. All other bits read 0.
- Register reset values: Status BEV=RESET_BEV, IM=8'hff, ERL=0, EXL=0, IE=1. Cause = 0. EPC = 0. Sync flops = 0.
- Output reset values: `int_req`=0, `epc_out`=0, `exl`=0, `erl`=0, `bev`=RESET_BEV.
- mtc0 to 12 writes BEV, IM, ERL, EXL and IE.
- mtc0 to 13 writes IP[1:0] only. Other Cause bits are read-only.
- mtc0 to 14 writes all 32 bits of EPC.
- Writes to any other address are ignored.
- Hardware lines: each `hw_int[i]` passes through SYNC_STAGES flops. IP[2+i] equals the last stage and is level-following, not latched. IP bits for i ≥ NUM_HW_INT read 0.
- int_req = IE & ~EXL & ~ERL & |(IP & IM). It is combinational from registered state.
- Exception entry (`exc_valid`):
  - EXL←1 and ExcCode←exc_code.
  - If EXL was 0: BD←exc_bd, and EPC←exc_bd ? exc_pc−4 : exc_pc (mod 2^32).
  - If EXL was already 1: EPC and BD are unchanged. Only ExcCode updates.
- ERET: if ERL=1, ERL←0. Otherwise EXL←0.
- Same-cycle priority per field is exc_valid > eret > mtc0.
  - Example: exc_valid + we to Status sets EXL=1 but still writes IM, IE, BEV, ERL from wdata.
  - exc_valid + eret acts as exc_valid only.
- Reads: raddr 12/13/14 return the register; any other address returns 0. A read in the same cycle as a write to that register returns the old value.

## Timing
- Register updates take effect at the rising edge where the strobe is sampled high. Dependent outputs change after that edge.
- hw_int rising → IP bit set after SYNC_STAGES edges → int_req high in the same cycle if enabled. Falling edge has the same latency.
- mtc0 IM/IE/IP write → int_req reflects the new value the cycle after the write edge.
- exc_valid at edge k → exl=1, int_req=0 from edge k. epc_out is valid from edge k.
- rst_n low clears all state immediately, regardless of clk, including mid-exception or mid-sync. Sync stages restart from 0.

## Test plan
- Reset: rst_n low mid-cycle → Status reads 0x004_0ff01 pattern (BEV=1, IM=ff, IE=1), i.e. 0x0040FF01. Cause=0, EPC=0, int_req=0.
- hw_int[3]=1 with IE=1, IM=ff → IP[5] set and int_req=1 exactly SYNC_STAGES edges later. Deassert → int_req=0 after the same latency.
- Nested entry: exc_valid with exc_pc=0x00400010, bd=1, code=4 → EPC=0x0040000C, BD=1, ExcCode=4. A second exc_valid with code 5 leaves EPC/BD unchanged and sets ExcCode=5.
- ERET: with ERL=1, EXL=1 → ERL=0, EXL=1. A second eret → EXL=0, and int_req is restored if IP&IM≠0.
- mtc0 Cause wdata=0xFFFFFFFF → only IP[1:0]=3 changes. int_req=1 with IM[1:0] set. Clearing IM → int_req=0 on the next cycle.
- Collision: exc_valid + eret + we(12, IE=0) in one cycle → EXL=1, IE=0. mfc0 12 in that cycle returns the old value.
